// File: rtl/priority_arb_pkg.sv
// Shared types and helpers for the 8-way MSB-first priority / round-robin arbiter.
package priority_arb_pkg;
  localparam int NREQ = 8;
  localparam int IDW  = 3;

  typedef enum logic {ST_IDLE, ST_GRANT} state_e;

  // Bits start..0 form the first search segment; the wrap segment is searched only when it is empty.
  function automatic logic [NREQ-1:0] rotate_mask(input logic [IDW-1:0] start);
    logic [NREQ-1:0] m;
    for (int i = 0; i < NREQ; i++) m[i] = (i <= int'(start));
    return m;
  endfunction
endpackage

// File: rtl/priority_pick.sv
// Combinational picker: first set bit of req, searching downward and cyclically from start.
module priority_pick
  import priority_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  start,
  output logic            found,
  output logic [IDW-1:0]  idx
);
  logic [NREQ-1:0] hi;
  logic [NREQ-1:0] cand;

  always_comb begin
    hi    = req & rotate_mask(start);
    cand  = (|hi) ? hi : req;
    found = |req;
    idx   = '0;
    // ascending scan, so the highest set candidate bit wins
    for (int i = 0; i < NREQ; i++) if (cand[i]) idx = IDW'(i);
  end
endmodule

// File: rtl/priority_arbiter8.sv
// 8-way arbiter with fixed / round-robin policy, grant hold until release, and hold timeout.
module priority_arbiter8
  import priority_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_vld,
  output logic [IDW-1:0]  gnt_id,
  output logic            expire
);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            vld_q, vld_d;
  logic [IDW-1:0]  gid_q, gid_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            exp_q, exp_d;

  logic [IDW-1:0]  start;
  logic            found;
  logic [IDW-1:0]  pick;

  // round-robin begins just below the previous winner so it is searched last
  assign start = mode ? (last_q - 3'd1) : 3'd7;

  priority_pick u_pick (
    .req   (req),
    .start (start),
    .found (found),
    .idx   (pick)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    gid_d   = gid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    exp_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && found) begin
          state_d = ST_GRANT;
          gnt_d   = NREQ'(1) << pick;
          vld_d   = 1'b1;
          gid_d   = pick;
          last_d  = pick;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (!req[gid_q] || !en) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
          gid_d   = '0;
        end else if (cnt_q >= HOLD_LAST) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
          gid_d   = '0;
          exp_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      gid_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = vld_q;
  assign gnt_id  = gid_q;
  assign expire  = exp_q;
endmodule

// File: tb/tb_priority_arbiter8.sv
// Vector-table bench for priority_arbiter8 (MAX_HOLD=4) with an expected-result queue.
module tb_priority_arbiter8;
  logic       clk = 1'b0;
  logic       rst_n, en, mode;
  logic [7:0] req, gnt;
  logic       gnt_vld, expire;
  logic [2:0] gnt_id;

  always #5 clk = ~clk;

  priority_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .req(req),
    .gnt(gnt), .gnt_vld(gnt_vld), .gnt_id(gnt_id), .expire(expire)
  );

  typedef struct packed {
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       exp;
  } vec_t;

  typedef struct packed {
    logic [7:0] gnt;
    logic       vld;
    logic [2:0] id;
    logic       exp;
  } obs_t;

  vec_t vecs[$];
  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] oh(input int w);
    return 8'(1) << w;
  endfunction

  function automatic void add(input logic e, input logic m, input logic [7:0] r,
                              input logic [7:0] g, input int id, input logic x);
    vec_t v;
    v.en = e; v.mode = m; v.req = r; v.gnt = g; v.id = 3'(id); v.exp = x;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input obs_t want);
    obs_t got;
    got.gnt = gnt; got.vld = gnt_vld; got.id = gnt_id; got.exp = expire;
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got gnt=%h vld=%b id=%0d expire=%b, want gnt=%h vld=%b id=%0d expire=%b",
               name, got.gnt, got.vld, got.id, got.exp, want.gnt, want.vld, want.id, want.exp);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    obs_t e;
    @(negedge clk);
    en = v.en; mode = v.mode; req = v.req;
    e.gnt = v.gnt; e.vld = |v.gnt; e.id = v.id; e.exp = v.exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(name, sb.pop_front());
  endtask

  initial begin
    obs_t zero;
    vec_t v;
    zero = '0;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; req = 8'h00;
    repeat (2) @(posedge clk);
    #1 check("reset", zero);
    @(negedge clk) rst_n = 1'b1;

    // round-robin with all requesting: each winner holds 2 cycles, then drops for one edge
    for (int k = 0; k < 9; k++) begin
      int w;
      w = (15 - k) % 8;
      add(1, 1, 8'hFF, oh(w), w, 0);
      add(1, 1, 8'hFF, oh(w), w, 0);
      add(1, 1, 8'hFF & ~oh(w), 8'h00, 0, 0);
    end
    // fixed priority and handoff through one idle cycle
    add(1, 0, 8'h25, 8'h20, 5, 0);
    add(1, 0, 8'h25, 8'h20, 5, 0);
    add(1, 0, 8'h05, 8'h00, 0, 0);
    add(1, 0, 8'h05, 8'h04, 2, 0);
    add(1, 0, 8'h01, 8'h00, 0, 0);
    // no requests: outputs stay quiet
    add(1, 0, 8'h00, 8'h00, 0, 0);
    add(1, 0, 8'h00, 8'h00, 0, 0);
    add(1, 0, 8'h00, 8'h00, 0, 0);
    // timeout after 4 visible cycles, expire pulse, then re-grant
    add(1, 0, 8'h01, 8'h01, 0, 0);
    add(1, 0, 8'h01, 8'h01, 0, 0);
    add(1, 0, 8'h01, 8'h01, 0, 0);
    add(1, 0, 8'h01, 8'h01, 0, 0);
    add(1, 0, 8'h01, 8'h00, 0, 1);
    add(1, 0, 8'h01, 8'h01, 0, 0);
    add(1, 0, 8'h01, 8'h01, 0, 0);
    add(1, 0, 8'h01, 8'h01, 0, 0);
    add(1, 0, 8'h01, 8'h01, 0, 0);
    // release on the same edge the hold count is exhausted
    add(1, 0, 8'h00, 8'h00, 0, 0);
    add(1, 0, 8'h00, 8'h00, 0, 0);
    // enable drop revokes without expire, no grants while disabled
    add(1, 0, 8'h08, 8'h08, 3, 0);
    add(1, 0, 8'h08, 8'h08, 3, 0);
    add(0, 0, 8'h08, 8'h00, 0, 0);
    add(0, 0, 8'h08, 8'h00, 0, 0);
    add(0, 0, 8'h08, 8'h00, 0, 0);
    add(1, 0, 8'h08, 8'h08, 3, 0);
    add(1, 0, 8'h00, 8'h00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // asynchronous reset in the middle of a grant
    v = '0; v.en = 1'b1; v.req = 8'h10; v.gnt = 8'h10; v.id = 3'd4;
    apply(v, "rst_pre_grant");
    @(negedge clk) rst_n = 1'b0;
    #1 check("rst_immediate", zero);
    v.gnt = 8'h00; v.id = 3'd0;
    apply(v, "rst_held");
    @(negedge clk) rst_n = 1'b1;
    v.gnt = 8'h10; v.id = 3'd4;
    apply(v, "rst_regrant");
    v.req = 8'h00; v.gnt = 8'h00; v.id = 3'd0;
    apply(v, "rst_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
